// File: rtl/axi2mem_w_fifo.sv
// AXI W-channel buffer: DEPTH-entry circular FIFO with fill/burst occupancy and
// optional store-and-forward release (a burst is held until its last beat is stored).
module axi2mem_w_fifo #(
    parameter int DATA_WIDTH = 64,
    parameter int USER_WIDTH = 6,
    parameter int DEPTH      = 4,
    parameter int STORE_FWD  = 0,
    parameter int STRB_WIDTH = DATA_WIDTH / 8,
    parameter int CNT_WIDTH  = $clog2(DEPTH + 1)
) (
    input  logic                  clk_i,
    input  logic                  rst_i,
    input  logic                  slave_valid_i,
    input  logic [DATA_WIDTH-1:0] slave_data_i,
    input  logic [STRB_WIDTH-1:0] slave_strb_i,
    input  logic [USER_WIDTH-1:0] slave_user_i,
    input  logic                  slave_last_i,
    output logic                  slave_ready_o,
    output logic                  master_valid_o,
    output logic [DATA_WIDTH-1:0] master_data_o,
    output logic [STRB_WIDTH-1:0] master_strb_o,
    output logic [USER_WIDTH-1:0] master_user_o,
    output logic                  master_last_o,
    input  logic                  master_ready_i,
    output logic [CNT_WIDTH-1:0]  fill_o,
    output logic [CNT_WIDTH-1:0]  bursts_o
);
    localparam int PTR_WIDTH   = $clog2(DEPTH);
    localparam int ENTRY_WIDTH = USER_WIDTH + STRB_WIDTH + DATA_WIDTH + 1;
    localparam logic [CNT_WIDTH-1:0] FULL_CNT = CNT_WIDTH'(DEPTH);

    logic [ENTRY_WIDTH-1:0] mem_q [DEPTH];
    logic [ENTRY_WIDTH-1:0] head;
    logic [PTR_WIDTH-1:0]   wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
    logic [CNT_WIDTH-1:0]   count_q, count_d, bursts_q, bursts_d;
    logic                   stream_q, stream_d;
    logic                   push, pop, push_last, pop_last;
    logic                   not_empty, release_ok;

    // Ready depends only on registered state (plus reset), never on master_ready_i.
    assign slave_ready_o = rst_i | (count_q != FULL_CNT);
    assign push          = slave_valid_i & slave_ready_o & ~rst_i;
    assign pop           = master_valid_o & master_ready_i;
    assign push_last     = push & slave_last_i;
    assign pop_last      = pop & master_last_o;

    assign not_empty  = (count_q != '0);
    // The full term lets bursts longer than DEPTH drain instead of deadlocking.
    assign release_ok = (bursts_q != '0) | (count_q == FULL_CNT) | stream_q;
    assign master_valid_o = (STORE_FWD == 0) ? not_empty : (not_empty & release_ok);

    assign head          = mem_q[rd_ptr_q];
    assign master_last_o = head[0];
    assign master_data_o = head[DATA_WIDTH:1];
    assign master_strb_o = head[DATA_WIDTH+STRB_WIDTH:DATA_WIDTH+1];
    assign master_user_o = head[ENTRY_WIDTH-1 -: USER_WIDTH];

    assign fill_o   = count_q;
    assign bursts_o = bursts_q;

    always_ff @(posedge clk_i) begin
        if (push) begin
            mem_q[wr_ptr_q] <= {slave_user_i, slave_strb_i, slave_data_i, slave_last_i};
        end
    end

    always_comb begin
        wr_ptr_d = push ? wr_ptr_q + PTR_WIDTH'(1) : wr_ptr_q;
        rd_ptr_d = pop  ? rd_ptr_q + PTR_WIDTH'(1) : rd_ptr_q;

        count_d = count_q;
        case ({push, pop})
            2'b10:   count_d = count_q + CNT_WIDTH'(1);
            2'b01:   count_d = count_q - CNT_WIDTH'(1);
            default: count_d = count_q;
        endcase

        bursts_d = bursts_q;
        case ({push_last, pop_last})
            2'b10:   bursts_d = bursts_q + CNT_WIDTH'(1);
            2'b01:   bursts_d = bursts_q - CNT_WIDTH'(1);
            default: bursts_d = bursts_q;
        endcase

        // Once a burst starts leaving, keep it flowing until its last beat.
        stream_d = stream_q;
        if (pop) begin
            stream_d = ~master_last_o;
        end
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
            bursts_q <= '0;
            stream_q <= 1'b0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
            bursts_q <= bursts_d;
            stream_q <= stream_d;
        end
    end

    always @(posedge clk_i) begin
        if (!rst_i) begin
            assert (!(push && (count_q == FULL_CNT)));
            assert (!(pop && (count_q == '0)));
            assert (bursts_q <= count_q);
        end
    end
endmodule

// File: tb/tb_axi2mem_w_fifo.sv
// Directed bench: instance a is cut-through (DEPTH=4), instance b is
// store-and-forward (DEPTH=4); expected values are worked out by hand.
module tb_axi2mem_w_fifo;
    localparam int DW = 64;
    localparam int UW = 6;
    localparam int SW = 8;
    localparam int CW = 3;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    int n_tests = 0;
    int n_fail  = 0;

    logic          a_rst, a_valid_i, a_last_i, a_ready_o, a_mvalid, a_mlast, a_mready;
    logic [DW-1:0] a_data_i, a_mdata;
    logic [SW-1:0] a_strb_i, a_mstrb;
    logic [UW-1:0] a_user_i, a_muser;
    logic [CW-1:0] a_fill, a_bursts;

    logic          b_rst, b_valid_i, b_last_i, b_ready_o, b_mvalid, b_mlast, b_mready;
    logic [DW-1:0] b_data_i, b_mdata;
    logic [SW-1:0] b_strb_i, b_mstrb;
    logic [UW-1:0] b_user_i, b_muser;
    logic [CW-1:0] b_fill, b_bursts;

    axi2mem_w_fifo #(.DATA_WIDTH(DW), .USER_WIDTH(UW), .DEPTH(4), .STORE_FWD(0)) u_a (
        .clk_i(clk), .rst_i(a_rst),
        .slave_valid_i(a_valid_i), .slave_data_i(a_data_i), .slave_strb_i(a_strb_i),
        .slave_user_i(a_user_i), .slave_last_i(a_last_i), .slave_ready_o(a_ready_o),
        .master_valid_o(a_mvalid), .master_data_o(a_mdata), .master_strb_o(a_mstrb),
        .master_user_o(a_muser), .master_last_o(a_mlast), .master_ready_i(a_mready),
        .fill_o(a_fill), .bursts_o(a_bursts)
    );

    axi2mem_w_fifo #(.DATA_WIDTH(DW), .USER_WIDTH(UW), .DEPTH(4), .STORE_FWD(1)) u_b (
        .clk_i(clk), .rst_i(b_rst),
        .slave_valid_i(b_valid_i), .slave_data_i(b_data_i), .slave_strb_i(b_strb_i),
        .slave_user_i(b_user_i), .slave_last_i(b_last_i), .slave_ready_o(b_ready_o),
        .master_valid_o(b_mvalid), .master_data_o(b_mdata), .master_strb_o(b_mstrb),
        .master_user_o(b_muser), .master_last_o(b_mlast), .master_ready_i(b_mready),
        .fill_o(b_fill), .bursts_o(b_bursts)
    );

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h, expected %0h", tag, got, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic a_drive(input logic v, input logic [63:0] d, input logic l);
        a_valid_i = v;
        a_data_i  = d;
        a_last_i  = l;
        a_user_i  = d[5:0];
    endtask

    task automatic b_drive(input logic v, input logic [63:0] d, input logic l);
        b_valid_i = v;
        b_data_i  = d;
        b_last_i  = l;
        b_user_i  = d[5:0];
    endtask

    int first_valid;
    int last_pop;
    int sent;
    int rcvd;
    logic acc;

    initial begin
        a_rst = 1'b1; b_rst = 1'b1;
        a_strb_i = 8'hFF; b_strb_i = 8'hFF;
        a_drive(1'b0, 64'h0, 1'b0);
        b_drive(1'b0, 64'h0, 1'b0);
        a_mready = 1'b0; b_mready = 1'b0;
        step(); step();
        a_rst = 1'b0; b_rst = 1'b0;
        #1;

        chk("rst_a_valid", a_mvalid, 0);
        chk("rst_a_ready", a_ready_o, 1);
        chk("rst_a_fill", a_fill, 0);
        chk("rst_a_bursts", a_bursts, 0);
        chk("rst_b_valid", b_mvalid, 0);
        chk("rst_b_ready", b_ready_o, 1);

        // Cut-through: 6 beats, one in, one out per cycle.
        a_mready = 1'b1;
        for (int i = 0; i < 6; i++) begin
            a_drive(1'b1, 64'hD0 + 64'(i), i == 5);
            step();
            chk("ct_valid", a_mvalid, 1);
            chk("ct_data", a_mdata, 64'hD0 + 64'(i));
            chk("ct_last", a_mlast, (i == 5) ? 1 : 0);
            chk("ct_fill", a_fill, 1);
            chk("ct_bursts", a_bursts, (i == 5) ? 1 : 0);
        end
        chk("ct_user", a_muser, 6'h15);
        chk("ct_strb", a_mstrb, 8'hFF);
        a_drive(1'b0, 64'h0, 1'b0);
        step();
        chk("ct_drained_valid", a_mvalid, 0);
        chk("ct_drained_fill", a_fill, 0);
        chk("ct_drained_bursts", a_bursts, 0);

        // Full / backpressure.
        a_mready = 1'b0;
        for (int i = 0; i < 4; i++) begin
            chk("full_ready_pre", a_ready_o, 1);
            a_drive(1'b1, 64'hE0 + 64'(i), 1'b0);
            step();
        end
        chk("full_ready", a_ready_o, 0);
        chk("full_fill", a_fill, 4);
        a_drive(1'b1, 64'hE4, 1'b1);
        step();
        chk("full_hold_fill", a_fill, 4);
        chk("full_hold_head", a_mdata, 64'hE0);
        a_mready = 1'b1;
        step();
        a_mready = 1'b0;
        chk("full_pop_fill", a_fill, 3);
        chk("full_pop_ready", a_ready_o, 1);
        chk("full_pop_head", a_mdata, 64'hE1);
        step();
        chk("full_e4_fill", a_fill, 4);
        chk("full_e4_bursts", a_bursts, 1);
        a_drive(1'b0, 64'h0, 1'b0);
        a_mready = 1'b1;
        for (int j = 1; j < 5; j++) begin
            chk("full_drain_valid", a_mvalid, 1);
            chk("full_drain_data", a_mdata, 64'hE0 + 64'(j));
            step();
        end
        chk("full_drain_empty", a_mvalid, 0);

        // Simultaneous push/pop at fill 2 across pointer wrap.
        a_mready = 1'b0;
        for (int i = 0; i < 2; i++) begin
            a_drive(1'b1, 64'hF00 + 64'(i), i[0]);
            step();
        end
        chk("pp_fill_init", a_fill, 2);
        chk("pp_bursts_init", a_bursts, 1);
        a_mready = 1'b1;
        for (int i = 0; i < 10; i++) begin
            a_drive(1'b1, 64'hF00 + 64'(i + 2), (i % 2) == 1);
            step();
            chk("pp_fill", a_fill, 2);
            chk("pp_bursts", a_bursts, 1);
            chk("pp_head", a_mdata, 64'hF00 + 64'(i + 1));
            chk("pp_last", a_mlast, ((i + 1) % 2 == 1) ? 1 : 0);
        end
        a_drive(1'b0, 64'h0, 1'b0);
        step();
        step();
        chk("pp_drain_fill", a_fill, 0);

        // Reset mid-burst.
        a_mready = 1'b0;
        for (int i = 0; i < 3; i++) begin
            a_drive(1'b1, 64'hA0 + 64'(i), 1'b0);
            step();
        end
        chk("mr_fill", a_fill, 3);
        chk("mr_valid", a_mvalid, 1);
        a_drive(1'b1, 64'hAF, 1'b1);
        a_rst = 1'b1;
        #1;
        chk("mr_ready_in_rst", a_ready_o, 1);
        step();
        a_rst = 1'b0;
        a_drive(1'b0, 64'h0, 1'b0);
        #1;
        chk("mr_post_valid", a_mvalid, 0);
        chk("mr_post_fill", a_fill, 0);
        chk("mr_post_bursts", a_bursts, 0);
        chk("mr_post_ready", a_ready_o, 1);
        a_mready = 1'b1;
        a_drive(1'b1, 64'hB0, 1'b0);
        step();
        chk("mr_new0", a_mdata, 64'hB0);
        a_drive(1'b1, 64'hB1, 1'b1);
        step();
        chk("mr_new1", a_mdata, 64'hB1);
        chk("mr_new1_last", a_mlast, 1);
        a_drive(1'b0, 64'h0, 1'b0);
        step();
        chk("mr_new_empty", a_mvalid, 0);

        // Store-and-forward: 3-beat burst with a 2-cycle gap before the last beat.
        b_mready = 1'b1;
        b_drive(1'b1, 64'hC0, 1'b0);
        step();
        chk("sf_h0_valid", b_mvalid, 0);
        b_drive(1'b1, 64'hC1, 1'b0);
        step();
        chk("sf_h1_valid", b_mvalid, 0);
        chk("sf_h1_fill", b_fill, 2);
        b_drive(1'b0, 64'h0, 1'b0);
        step();
        chk("sf_gap1_valid", b_mvalid, 0);
        step();
        chk("sf_gap2_valid", b_mvalid, 0);
        b_drive(1'b1, 64'hC2, 1'b1);
        step();
        b_drive(1'b0, 64'h0, 1'b0);
        chk("sf_rel_valid", b_mvalid, 1);
        chk("sf_rel_bursts", b_bursts, 1);
        for (int j = 0; j < 3; j++) begin
            chk("sf_out_valid", b_mvalid, 1);
            chk("sf_out_data", b_mdata, 64'hC0 + 64'(j));
            chk("sf_out_bursts", b_bursts, 1);
            step();
        end
        chk("sf_end_valid", b_mvalid, 0);
        chk("sf_end_bursts", b_bursts, 0);
        chk("sf_end_fill", b_fill, 0);

        // Store-and-forward overflow: 7-beat burst into 4 entries.
        first_valid = -1;
        last_pop = -1;
        sent = 0;
        rcvd = 0;
        for (int cyc = 0; cyc < 40 && rcvd < 7; cyc++) begin
            b_drive(sent < 7, 64'h700 + 64'(sent), sent == 6);
            acc = b_valid_i & b_ready_o;
            if (b_mvalid && first_valid < 0) begin
                first_valid = cyc;
                chk("ovf_fill_at_release", b_fill, 4);
            end
            if (b_mvalid) begin
                chk("ovf_data", b_mdata, 64'h700 + 64'(rcvd));
                rcvd++;
                last_pop = cyc;
            end
            if (acc) sent++;
            step();
        end
        b_drive(1'b0, 64'h0, 1'b0);
        chk("ovf_first_valid_cyc", 64'(first_valid), 4);
        chk("ovf_last_pop_cyc", 64'(last_pop), 10);
        chk("ovf_rcvd", 64'(rcvd), 7);
        chk("ovf_end_fill", b_fill, 0);
        chk("ovf_end_valid", b_mvalid, 0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule
